mf_coeff_loader: RTL and testbench
==================================

MF_COEFF_LOADER -- requirements
Module: mf_coeff_loader

Interface
REQ-001 SHALL have parameter LENGTH, default 800, the number of complex coefficient entries stored.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, the signed width of each real and imaginary part.
REQ-003 SHALL have parameter REVERSE, default 1: 1 stores time-reversed, 0 stores in arrival order.
REQ-004 SHALL have parameter CONJUGATE, default 1: 1 negates the imaginary part on store, 0 stores it unchanged.
REQ-005 SHALL have ports: clock input 1 system clock; reset input 1 reset, synchronous, active-high.
REQ-006 SHALL have ports: enable input 1 starts a load; upstreamEnable output 1 drives the upstream coefficient source enable.
REQ-007 SHALL have ports: inputValid input 1 sample strobe; inputRe, inputIm input DATA_WIDTH signed upstream sample; inputFinished input 1 upstream dataFinishedFlag.
REQ-008 SHALL have ports: readAddress input clog2(LENGTH) filter-core read index; readRe, readIm output DATA_WIDTH signed read data.
REQ-009 SHALL have ports: coeffReady output 1 table valid; loadCount output clog2(LENGTH+1) samples captured; overflowError, underflowError output 1 status flags.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-011 IDLE: all outputs low/zero; enable high -> LOAD next cycle, with the sample counter cleared on entry.
REQ-012 LOAD: upstreamEnable high; each cycle with inputValid high writes one sample and increments loadCount.
REQ-013 Write address SHALL be LENGTH-1-k when REVERSE=1 and k when REVERSE=0, where k is the sample index.
REQ-014 With CONJUGATE=1 the stored imaginary part SHALL be -inputIm; the most negative value SHALL saturate to the most positive value, with no wrap.
REQ-015 The real part SHALL be stored unmodified.
REQ-016 LOAD -> DONE when the LENGTH-th sample is written, or when inputFinished is high.
REQ-017 If inputValid and inputFinished are high in the same cycle, the sample SHALL be written before moving to DONE.
REQ-018 If inputFinished ends LOAD with loadCount<LENGTH, underflowError SHALL be set.
REQ-019 After an underflow, reads of unwritten logical indices SHALL return 0+0j.
REQ-020 If inputValid is high in the cycle after the LENGTH-th write, or while in DONE, overflowError SHALL be set and the sample discarded.
REQ-021 DONE: upstreamEnable low; coeffReady high; flags and loadCount held.
REQ-022 In DONE, enable low-then-high (rising edge) SHALL re-enter LOAD and clear the flags and counter.
REQ-023 Read latency SHALL be 1 cycle: readAddress sampled at edge N appears on readRe/readIm after edge N.
REQ-024 Reads SHALL return 0 whenever coeffReady is low.
REQ-025 readAddress >= LENGTH SHALL return 0.
REQ-026 Writes and reads SHALL be independent; a read of an entry being written in the same cycle returns the old data.

Reset
REQ-027 reset SHALL be sampled on clock edges only.
REQ-028 On reset the FSM SHALL go to IDLE, and upstreamEnable, coeffReady, loadCount, both flags, readRe and readIm SHALL all be 0.
REQ-029 Reset mid-LOAD SHALL abort the load, and RAM contents SHALL be treated as invalid until the next completed load.
REQ-030 RAM contents SHALL NOT require clearing on reset.

Structure
REQ-031 Shared package/include mf_pkg SHALL hold DATA_WIDTH default, LENGTH default and FSM state encodings, reused by the matched-filter stages.
REQ-032 Storage SHALL be the sub-module mf_coeff_ram: simple dual-port, one write and one registered read port, inferable as block RAM.
REQ-033 Saturating negation SHALL live in the loader, not in the RAM.

Verification (LENGTH=8, DATA_WIDTH=16)
REQ-034 Scenario: REVERSE=1, CONJUGATE=1, feed re=1..8, im=10..80 -> address 0 reads 8-80j, address 7 reads 1-10j; coeffReady high after 8th write; loadCount=8.
REQ-035 Scenario: inputIm=-32768 with CONJUGATE=1 -> stored im=+32767.
REQ-036 Scenario: inputFinished together with 5th valid sample -> loadCount=5, underflowError=1; REVERSE=0 addresses 5..7 read 0.
REQ-037 Scenario: 9 consecutive valid samples -> first 8 stored, overflowError=1, 9th not written.
REQ-038 Scenario: reset asserted after 3 samples -> next cycle IDLE, all outputs 0; a fresh full load then matches REQ-034.
REQ-039 Scenario: read any address with coeffReady low -> 0; in DONE, address change -> new data exactly one cycle later.

Source files
------------

// File: rtl/mf_pkg.sv
// ---------------------------------------------------------------------------
// mf_pkg
// Shared definitions for the matched-filter stages: default sample width,
// default coefficient table length and the loader FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package mf_pkg;

    localparam int unsigned MF_DATA_WIDTH = 16;
    localparam int unsigned MF_LENGTH     = 800;

    typedef enum logic [1:0] {
        MF_IDLE = 2'd0,
        MF_LOAD = 2'd1,
        MF_DONE = 2'd2
    } mf_state_e;

endpackage

// File: rtl/mf_coeff_ram.sv
// ---------------------------------------------------------------------------
// mf_coeff_ram
// Simple dual-port coefficient store: one synchronous write port and one
// registered read port. Read-before-write: a read of the entry being written
// on the same edge returns the previous contents. No reset, so it maps onto
// block RAM.
//
// Ports
//   clk_i      : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data ({re, im})
//   rd_addr_i  : read address, sampled on the clock edge
//   rd_data_o  : registered read data
// ---------------------------------------------------------------------------
module mf_coeff_ram
    import mf_pkg::*;
#(
    parameter int unsigned DEPTH  = MF_LENGTH,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned WIDTH  = 2 * MF_DATA_WIDTH
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/mf_coeff_loader.sv
// ---------------------------------------------------------------------------
// mf_coeff_loader
// Captures a stream of complex coefficients from an upstream source into a
// table, optionally time-reversed and conjugated, and serves it to the
// filter core through a 1-cycle-latency read port.
//
// Ports
//   clock, reset    : system clock, synchronous active-high reset
//   enable          : level in IDLE / rising edge in DONE starts a load
//   upstreamEnable  : high while loading
//   inputValid      : sample strobe
//   inputRe/Im      : upstream sample
//   inputFinished   : upstream end-of-data flag
//   readAddress     : filter-core read index
//   readRe/readIm   : read data, 0 when table not ready / entry not loaded
//   coeffReady      : table valid
//   loadCount       : number of samples captured in the last load
//   overflowError   : valid sample arrived after the table was full/closed
//   underflowError  : load ended by inputFinished before the table filled
// ---------------------------------------------------------------------------
module mf_coeff_loader
    import mf_pkg::*;
#(
    parameter int unsigned LENGTH     = MF_LENGTH,
    parameter int unsigned DATA_WIDTH = MF_DATA_WIDTH,
    parameter int unsigned REVERSE    = 1,
    parameter int unsigned CONJUGATE  = 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 enable,
    output logic                                 upstreamEnable,
    input  logic                                 inputValid,
    input  logic signed [DATA_WIDTH-1:0]         inputRe,
    input  logic signed [DATA_WIDTH-1:0]         inputIm,
    input  logic                                 inputFinished,
    input  logic [$clog2(LENGTH)-1:0]            readAddress,
    output logic signed [DATA_WIDTH-1:0]         readRe,
    output logic signed [DATA_WIDTH-1:0]         readIm,
    output logic                                 coeffReady,
    output logic [$clog2(LENGTH+1)-1:0]          loadCount,
    output logic                                 overflowError,
    output logic                                 underflowError
);

    localparam int unsigned AW = $clog2(LENGTH);
    localparam int unsigned CW = $clog2(LENGTH + 1);

    localparam logic [CW-1:0] LEN_C  = CW'(LENGTH);
    localparam logic [CW-1:0] LAST_C = CW'(LENGTH - 1);

    localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    // Two's-complement negation with the single overflow case clamped.
    function automatic logic signed [DATA_WIDTH-1:0] sat_neg(
        input logic signed [DATA_WIDTH-1:0] v
    );
        if (v == S_MIN) begin
            return S_MAX;
        end
        return -v;
    endfunction

    mf_state_e       state_q;
    logic [CW-1:0]   count_q;
    logic            upen_q;
    logic            ready_q;
    logic            ovf_q;
    logic            unf_q;
    logic            en_prev_q;
    logic            rd_ok_q;
    logic            rd_ok_d;

    logic                        wr_en;
    logic [AW-1:0]               wr_addr;
    logic [2*DATA_WIDTH-1:0]     wr_data;
    logic [2*DATA_WIDTH-1:0]     rd_data;
    logic [CW-1:0]               rd_ext;
    logic [CW-1:0]               rd_k;

    // Write side: sample index k is the current count.
    always_comb begin
        wr_en   = (state_q == MF_LOAD) && inputValid;
        wr_addr = (REVERSE != 0) ? AW'(LAST_C - count_q) : AW'(count_q);
        wr_data = {inputRe, (CONJUGATE != 0) ? sat_neg(inputIm) : inputIm};
    end

    // Read side: map the physical address back to its sample index so that
    // entries not filled by the last load (underflow) read as zero even
    // though the RAM still holds older data there.
    always_comb begin
        rd_ext  = CW'(readAddress);
        rd_k    = (REVERSE != 0) ? (LAST_C - rd_ext) : rd_ext;
        rd_ok_d = ready_q && (rd_ext < LEN_C) && (rd_k < count_q);
    end

    mf_coeff_ram #(
        .DEPTH  (LENGTH),
        .ADDR_W (AW),
        .WIDTH  (2 * DATA_WIDTH)
    ) u_ram (
        .clk_i     (clock),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (readAddress),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ok_q <= 1'b0;
        end else begin
            rd_ok_q <= rd_ok_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= MF_IDLE;
            count_q   <= '0;
            upen_q    <= 1'b0;
            ready_q   <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            en_prev_q <= 1'b0;
        end else begin
            en_prev_q <= enable;
            unique case (state_q)
                MF_IDLE: begin
                    if (enable) begin
                        state_q <= MF_LOAD;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                        unf_q   <= 1'b0;
                        upen_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                MF_LOAD: begin
                    if (inputValid) begin
                        count_q <= count_q + 1'b1;
                        // Sample is written this cycle even when it is also
                        // the one that closes the load.
                        if ((count_q == LAST_C) || inputFinished) begin
                            state_q <= MF_DONE;
                            upen_q  <= 1'b0;
                            ready_q <= 1'b1;
                            unf_q   <= (count_q != LAST_C);
                        end
                    end else if (inputFinished) begin
                        state_q <= MF_DONE;
                        upen_q  <= 1'b0;
                        ready_q <= 1'b1;
                        unf_q   <= 1'b1;
                    end
                end
                MF_DONE: begin
                    if (enable && !en_prev_q) begin
                        state_q <= MF_LOAD;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                        unf_q   <= 1'b0;
                        upen_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end else if (inputValid) begin
                        ovf_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= MF_IDLE;
                    upen_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // ready_q is re-applied here so data vanishes the same cycle coeffReady drops.
    always_comb begin
        readRe = '0;
        readIm = '0;
        if (rd_ok_q && ready_q) begin
            readRe = rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
            readIm = rd_data[DATA_WIDTH-1:0];
        end
    end

    assign upstreamEnable = upen_q;
    assign coeffReady     = ready_q;
    assign loadCount      = count_q;
    assign overflowError  = ovf_q;
    assign underflowError = unf_q;

endmodule

// File: tb/tb_mf_coeff_loader.sv
// ---------------------------------------------------------------------------
// tb_mf_coeff_loader
// Directed bench for mf_coeff_loader with LENGTH=8, DATA_WIDTH=16. Two
// instances share the stimulus: dut_r (REVERSE=1, CONJUGATE=1) and
// dut_f (REVERSE=0, CONJUGATE=0).
// ---------------------------------------------------------------------------
module tb_mf_coeff_loader;

    localparam int unsigned LEN = 8;
    localparam int unsigned DW  = 16;

    logic                 clock;
    logic                 reset;
    logic                 enable;
    logic                 inputValid;
    logic signed [DW-1:0] inputRe;
    logic signed [DW-1:0] inputIm;
    logic                 inputFinished;
    logic [2:0]           readAddress;

    logic                 r_upen, r_ready, r_ovf, r_unf;
    logic [3:0]           r_cnt;
    logic signed [DW-1:0] r_re, r_im;
    logic                 f_upen, f_ready, f_ovf, f_unf;
    logic [3:0]           f_cnt;
    logic signed [DW-1:0] f_re, f_im;

    int checks   = 0;
    int failures = 0;

    mf_coeff_loader #(
        .LENGTH(LEN), .DATA_WIDTH(DW), .REVERSE(1), .CONJUGATE(1)
    ) dut_r (
        .clock(clock), .reset(reset), .enable(enable),
        .upstreamEnable(r_upen), .inputValid(inputValid),
        .inputRe(inputRe), .inputIm(inputIm), .inputFinished(inputFinished),
        .readAddress(readAddress), .readRe(r_re), .readIm(r_im),
        .coeffReady(r_ready), .loadCount(r_cnt),
        .overflowError(r_ovf), .underflowError(r_unf)
    );

    mf_coeff_loader #(
        .LENGTH(LEN), .DATA_WIDTH(DW), .REVERSE(0), .CONJUGATE(0)
    ) dut_f (
        .clock(clock), .reset(reset), .enable(enable),
        .upstreamEnable(f_upen), .inputValid(inputValid),
        .inputRe(inputRe), .inputIm(inputIm), .inputFinished(inputFinished),
        .readAddress(readAddress), .readRe(f_re), .readIm(f_im),
        .coeffReady(f_ready), .loadCount(f_cnt),
        .overflowError(f_ovf), .underflowError(f_unf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic feed(input int re, input int im, input logic fin);
        inputValid    = 1'b1;
        inputRe       = DW'(re);
        inputIm       = DW'(im);
        inputFinished = fin;
        tick();
        inputValid    = 1'b0;
        inputFinished = 1'b0;
    endtask

    task automatic read_at(input logic [2:0] a);
        readAddress = a;
        tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_upen"},  r_upen,  0);
        check({tag, "_ready"}, r_ready, 0);
        check({tag, "_cnt"},   r_cnt,   0);
        check({tag, "_ovf"},   r_ovf,   0);
        check({tag, "_unf"},   r_unf,   0);
        check({tag, "_re"},    r_re,    0);
        check({tag, "_im"},    r_im,    0);
        check({tag, "_f_re"},  f_re,    0);
    endtask

    task automatic full_load_and_check(input string tag);
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) begin
                check({tag, "_ready_before_last"}, r_ready, 0);
                check({tag, "_cnt_before_last"},   r_cnt,   7);
            end
            feed(i, 10 * i, 1'b0);
        end
        check({tag, "_ready"}, r_ready, 1);
        check({tag, "_cnt"},   r_cnt,   8);
        check({tag, "_upen"},  r_upen,  0);
        check({tag, "_unf"},   r_unf,   0);
        read_at(3'd0);
        check({tag, "_r_a0_re"}, r_re, 8);
        check({tag, "_r_a0_im"}, r_im, -80);
        check({tag, "_f_a0_re"}, f_re, 1);
        check({tag, "_f_a0_im"}, f_im, 10);
        read_at(3'd7);
        check({tag, "_r_a7_re"}, r_re, 1);
        check({tag, "_r_a7_im"}, r_im, -10);
        check({tag, "_f_a7_re"}, f_re, 8);
        check({tag, "_f_a7_im"}, f_im, 80);
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        inputValid    = 1'b0;
        inputRe       = '0;
        inputIm       = '0;
        inputFinished = 1'b0;
        readAddress   = '0;
        tick();
        tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Full reversed/conjugated load.
        enable = 1'b1;
        tick();
        check("s1_upen", r_upen, 1);
        check("s1_cnt0", r_cnt, 0);
        readAddress = 3'd0;
        tick();
        check("s1_read_while_loading", r_re, 0);
        full_load_and_check("s1");
        enable = 1'b0;
        // Address change in DONE: old data until the next edge, then new.
        readAddress = 3'd3;
        #2;
        check("s1_lat_old", r_re, 1);
        tick();
        check("s1_lat_new_re", r_re, 5);
        check("s1_lat_new_im", r_im, -50);

        // Overflow plus conjugate saturation.
        enable = 1'b1;
        tick();
        check("s2_reload_ready", r_ready, 0);
        check("s2_reload_cnt", r_cnt, 0);
        check("s2_reload_upen", r_upen, 1);
        feed(101, -32768, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            feed(100 + i, i, 1'b0);
        end
        check("s2_ovf_before", r_ovf, 0);
        feed(109, 9, 1'b0);
        check("s2_ovf", r_ovf, 1);
        check("s2_f_ovf", f_ovf, 1);
        check("s2_cnt", r_cnt, 8);
        enable = 1'b0;
        read_at(3'd7);
        check("s2_sat_re", r_re, 101);
        check("s2_sat_im", r_im, 32767);
        read_at(3'd0);
        check("s2_r_a0_re", r_re, 108);
        check("s2_r_a0_im", r_im, -8);
        check("s2_f_a0_im", f_im, -32768);
        read_at(3'd7);
        check("s2_f_a7_re", f_re, 108);
        check("s2_f_a7_im", f_im, 8);

        // Underflow: inputFinished together with the 5th sample.
        enable = 1'b1;
        tick();
        check("s3_ovf_cleared", r_ovf, 0);
        for (int i = 1; i <= 5; i++) begin
            feed(20 + i, i, (i == 5));
        end
        check("s3_cnt", f_cnt, 5);
        check("s3_unf", f_unf, 1);
        check("s3_r_unf", r_unf, 1);
        check("s3_ready", f_ready, 1);
        enable = 1'b0;
        read_at(3'd4);
        check("s3_f_a4_re", f_re, 25);
        check("s3_f_a4_im", f_im, 5);
        for (int a = 5; a <= 7; a++) begin
            read_at(3'(a));
            check("s3_f_unwritten_re", f_re, 0);
            check("s3_f_unwritten_im", f_im, 0);
        end
        read_at(3'd3);
        check("s3_r_a3_re", r_re, 25);
        check("s3_r_a3_im", r_im, -5);
        read_at(3'd2);
        check("s3_r_unwritten", r_re, 0);

        // Reset mid-load, then a fresh full load.
        enable = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            feed(50 + i, i, 1'b0);
        end
        check("s4_cnt3", r_cnt, 3);
        reset = 1'b1;
        tick();
        check_idle_outputs("s4_reset");
        reset = 1'b0;
        tick();
        check("s4_upen", r_upen, 1);
        full_load_and_check("s4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
